// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared encodings for the writeback stage
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_H  = 3'b001,
        LD_HU = 3'b010,
        LD_B  = 3'b011,
        LD_BU = 3'b100
    } load_type_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_stage_load_fmt.sv
// rtl/wb_stage_load_fmt.sv - little-endian load lane select, extension and alignment check
module load_fmt
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        off,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (off)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];

        data       = rdata;
        misaligned = 1'b0;
        case (load_type)
            LD_H: begin
                data       = {{(DATA_W-16){half_v[15]}}, half_v};
                misaligned = off[0];
            end
            LD_HU: begin
                data       = {{(DATA_W-16){1'b0}}, half_v};
                misaligned = off[0];
            end
            LD_B:  data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_BU: data = {{(DATA_W-8){1'b0}}, byte_v};
            // Unknown encodings fall back to a full-word load.
            default: begin
                data       = rdata;
                misaligned = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, writeback select, write qualification and counters
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_load_type,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    input  logic [DATA_W-1:0] in_pc_plus8,
    output logic              write_en,
    output logic [REG_AW-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              misaligned,
    output logic [CNT_W-1:0]  misalign_cnt,
    output logic [31:0]       retire_cnt
);

    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              qual_q, qual_d;
    logic              mis_q, mis_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  misalign_cnt_q, misalign_cnt_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;

    logic [DATA_W-1:0] fmt_data;
    logic              fmt_mis;
    logic              capture;
    logic              cap_mis;
    logic [DATA_W-1:0] sel_data;
    logic              write_slot;

    load_fmt #(.DATA_W(DATA_W)) u_load_fmt (
        .rdata      (in_mem_rdata),
        .off        (in_alu_result[1:0]),
        .load_type  (in_load_type),
        .data       (fmt_data),
        .misaligned (fmt_mis)
    );

    always_comb begin
        capture = in_valid & ~stall & ~flush;
        cap_mis = (in_wb_sel == WB_LOAD) & fmt_mis;
        case (in_wb_sel)
            WB_LOAD: sel_data = fmt_data;
            WB_LINK: sel_data = in_pc_plus8;
            default: sel_data = in_alu_result;
        endcase

        valid_d        = valid_q;
        done_d         = done_q;
        qual_d         = qual_q;
        mis_d          = mis_q;
        dest_d         = dest_q;
        data_d         = data_q;
        misalign_cnt_d = misalign_cnt_q;
        retire_cnt_d   = retire_cnt_q;

        if (capture) begin
            valid_d      = 1'b1;
            done_d       = 1'b0;
            dest_d       = in_dest;
            data_d       = sel_data;
            qual_d       = in_reg_write & (in_dest != REG_AW'(REG_ZERO)) & ~cap_mis;
            mis_d        = cap_mis;
            retire_cnt_d = retire_cnt_q + 32'd1;
            if (cap_mis && (misalign_cnt_q != {CNT_W{1'b1}})) begin
                misalign_cnt_d = misalign_cnt_q + 1'b1;
            end
        end else begin
            // Without a stall an idle MEM stage leaves a bubble behind.
            if (flush || !stall) begin
                valid_d = 1'b0;
            end
            if (valid_q && !done_q) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q        <= 1'b0;
            done_q         <= 1'b0;
            qual_q         <= 1'b0;
            mis_q          <= 1'b0;
            dest_q         <= '0;
            data_q         <= '0;
            misalign_cnt_q <= '0;
            retire_cnt_q   <= '0;
        end else begin
            valid_q        <= valid_d;
            done_q         <= done_d;
            qual_q         <= qual_d;
            mis_q          <= mis_d;
            dest_q         <= dest_d;
            data_q         <= data_d;
            misalign_cnt_q <= misalign_cnt_d;
            retire_cnt_q   <= retire_cnt_d;
        end
    end

    assign write_slot   = valid_q & ~done_q;
    assign in_ready     = ~stall;
    assign write_en     = write_slot & qual_q;
    assign misaligned   = write_slot & mis_q;
    assign write_reg    = dest_q;
    assign write_data   = data_q;
    assign fwd_valid    = valid_q & qual_q;
    assign fwd_reg      = dest_q;
    assign fwd_data     = data_q;
    assign misalign_cnt = misalign_cnt_q;
    assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_dest = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [2:0]  in_load_type = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_mem_rdata = '0;
    logic [31:0] in_pc_plus8 = '0;
    logic        write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        misaligned;
    logic [7:0]  misalign_cnt;
    logic [31:0] retire_cnt;

    int errors = 0;
    int checks = 0;

    wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .in_reg_write (in_reg_write),
        .in_dest      (in_dest),
        .in_wb_sel    (in_wb_sel),
        .in_load_type (in_load_type),
        .in_alu_result(in_alu_result),
        .in_mem_rdata (in_mem_rdata),
        .in_pc_plus8  (in_pc_plus8),
        .write_en     (write_en),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .fwd_valid    (fwd_valid),
        .fwd_reg      (fwd_reg),
        .fwd_data     (fwd_data),
        .misaligned   (misaligned),
        .misalign_cnt (misalign_cnt),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference formatting from plain shifts and arithmetic; bit 32 is the misalign flag.
    function automatic logic [32:0] ref_fmt(input logic [31:0] rdata, input int off, input logic [2:0] lt);
        logic [31:0] v;
        logic        m;
        m = 1'b0;
        case (lt)
            3'd1, 3'd2: begin
                v = (rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
                if (lt == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
                m = (off % 2) != 0;
            end
            3'd3, 3'd4: begin
                v = (rdata >> (8 * off)) & 32'h0000_00FF;
                if (lt == 3'd3 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            default: begin
                v = rdata;
                m = off != 0;
            end
        endcase
        return {m, v};
    endfunction

    // Model of the held instruction: whether it exists, already had its write cycle, and what it carries.
    bit          m_valid, m_done, m_wr, m_mis;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    int unsigned m_ret;
    int          m_mcnt;

    always @(posedge clk or negedge rst) begin
        logic [32:0] f;
        bit          lmis;
        if (!rst) begin
            m_valid <= 0; m_done <= 0; m_wr <= 0; m_mis <= 0;
            m_dest <= '0; m_data <= '0; m_ret <= 0; m_mcnt <= 0;
        end else begin
            if (m_valid) m_done <= 1;
            if (in_valid && !stall && !flush) begin
                f    = ref_fmt(in_mem_rdata, int'(in_alu_result % 4), in_load_type);
                lmis = (in_wb_sel == 2'b01) && f[32];
                m_valid <= 1;
                m_done  <= 0;
                m_dest  <= in_dest;
                m_data  <= (in_wb_sel == 2'b01) ? f[31:0] : (in_wb_sel == 2'b10) ? in_pc_plus8 : in_alu_result;
                m_mis   <= lmis;
                m_wr    <= in_reg_write && in_dest != 0 && !lmis;
                m_ret   <= m_ret + 1;
                if (lmis && m_mcnt < 255) m_mcnt <= m_mcnt + 1;
            end else if (flush || !stall) begin
                m_valid <= 0;
            end
        end
    end

    always @(negedge clk) begin
        bit pend;
        pend = m_valid && !m_done;
        chk("write_en", write_en, pend && m_wr);
        if (pend && m_wr) begin
            chk("write_reg", write_reg, m_dest);
            chk("write_data", write_data, m_data);
        end
        chk("misaligned", misaligned, pend && m_mis);
        chk("fwd_valid", fwd_valid, m_valid && m_wr);
        if (m_valid && m_wr) begin
            chk("fwd_reg", fwd_reg, m_dest);
            chk("fwd_data", fwd_data, m_data);
        end
        chk("misalign_cnt", misalign_cnt, m_mcnt);
        chk("retire_cnt", retire_cnt, m_ret);
        chk("in_ready", in_ready, !stall);
    end

    task automatic drive(input logic v, input logic st, input logic fl, input logic rw,
                         input logic [4:0] dest, input logic [1:0] sel, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc);
        @(posedge clk);
        #2;
        in_valid = v; stall = st; flush = fl; in_reg_write = rw; in_dest = dest;
        in_wb_sel = sel; in_load_type = lt; in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus8 = pc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        #1;
        chk("reset write_en", write_en, 0);
        chk("reset fwd_valid", fwd_valid, 0);
        chk("reset retire_cnt", retire_cnt, 0);
        chk("reset misalign_cnt", misalign_cnt, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // ALU write
        drive(1, 0, 0, 1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
        idle();
        chk("alu write_en", write_en, 1);
        chk("alu write_reg", write_reg, 5);
        chk("alu write_data", write_data, 32'h1234_5678);
        chk("alu retire_cnt", retire_cnt, 1);
        idle();
        chk("alu write_en drop", write_en, 0);

        // Load formats back to back
        drive(1, 0, 0, 1, 5'd1, 2'd1, 3'd3, 32'h1000_0003, 32'h80FF_7F01, 32'h0);
        drive(1, 0, 0, 1, 5'd2, 2'd1, 3'd4, 32'h1000_0001, 32'h80FF_7F01, 32'h0);
        chk("LB off3", write_data, 32'hFFFF_FF80);
        drive(1, 0, 0, 1, 5'd3, 2'd1, 3'd1, 32'h1000_0002, 32'h80FF_7F01, 32'h0);
        chk("LBU off1", write_data, 32'h0000_007F);
        drive(1, 0, 0, 1, 5'd4, 2'd1, 3'd2, 32'h1000_0000, 32'h80FF_7F01, 32'h0);
        chk("LH off2", write_data, 32'hFFFF_80FF);
        idle();
        chk("LHU off0", write_data, 32'h0000_7F01);
        chk("LHU write_en", write_en, 1);

        // Misaligned LW
        drive(1, 0, 0, 1, 5'd7, 2'd1, 3'd0, 32'h2000_0002, 32'hDEAD_BEEF, 32'h0);
        idle();
        chk("mis write_en", write_en, 0);
        chk("mis pulse", misaligned, 1);
        chk("mis cnt1", misalign_cnt, 1);
        idle();
        chk("mis pulse drop", misaligned, 0);
        for (int i = 0; i < 299; i++)
            drive(1, 0, 0, 1, 5'd7, 2'd1, 3'd0, 32'h2000_0002, 32'hDEAD_BEEF, 32'h0);
        idle();
        chk("mis cnt sat", misalign_cnt, 255);

        // Register 0 suppression
        drive(1, 0, 0, 1, 5'd0, 2'd0, 3'd0, 32'hCAFE_0000, 32'h0, 32'h0);
        idle();
        chk("r0 write_en", write_en, 0);
        chk("r0 fwd_valid", fwd_valid, 0);
        chk("r0 retire_cnt", retire_cnt, 306);

        // Link and reserved select
        drive(1, 0, 0, 1, 5'd31, 2'd2, 3'd0, 32'h0000_0003, 32'h0, 32'h0000_4008);
        drive(1, 0, 0, 1, 5'd12, 2'd3, 3'd3, 32'h0000_A5A5, 32'hFFFF_FFFF, 32'h1);
        chk("link data", write_data, 32'h0000_4008);
        idle();
        chk("reserved sel data", write_data, 32'h0000_A5A5);

        // Stall then flush
        drive(1, 0, 0, 1, 5'd9, 2'd0, 3'd0, 32'h0000_0099, 32'h0, 32'h0);
        drive(0, 1, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        chk("stall write_en", write_en, 1);
        drive(0, 1, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        chk("stall no rewrite", write_en, 0);
        chk("stall fwd_valid", fwd_valid, 1);
        drive(0, 1, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        drive(1, 0, 1, 1, 5'd10, 2'd0, 3'd0, 32'h0000_0010, 32'h0, 32'h0);
        chk("held fwd_reg", fwd_reg, 9);
        idle();
        chk("flush fwd_valid", fwd_valid, 0);
        chk("flush write_en", write_en, 0);

        // Asynchronous reset while a write is pending
        drive(1, 0, 0, 1, 5'd11, 2'd0, 3'd0, 32'h0000_0011, 32'h0, 32'h0);
        drive(0, 1, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        chk("pre-reset write_en", write_en, 1);
        #1 rst = 1'b0;
        #1;
        chk("areset write_en", write_en, 0);
        chk("areset fwd_valid", fwd_valid, 0);
        chk("areset write_data", write_data, 0);
        chk("areset retire_cnt", retire_cnt, 0);
        chk("areset misalign_cnt", misalign_cnt, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("post-reset write_en", write_en, 0);
        chk("post-reset fwd_valid", fwd_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
